// File: rtl/io_port.sv
// CPU-side port block: an outbound {port, data} FIFO drained by a valid/ready
// consumer, and four inbound registers with per-port fresh/overrun flags.
module io_port #(
  parameter int DATA_W      = 8,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              we_port,
  input  logic              rd_port,
  input  logic [1:0]        port_sel,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_port,
  output logic [DATA_W-1:0] out_data,
  input  logic              in_strobe,
  input  logic [1:0]        in_port,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        in_fresh,
  output logic [3:0]        in_ovf
);

  localparam int PTR_W = $clog2(OFIFO_DEPTH);
  localparam int CNT_W = $clog2(OFIFO_DEPTH + 1);
  localparam int ENT_W = DATA_W + 2;

  logic [ENT_W-1:0]  mem_q [OFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, full;

  logic [DATA_W-1:0] in_reg_q [4];
  logic [DATA_W-1:0] in_reg_d [4];
  logic [3:0]        in_fresh_q, in_fresh_d;
  logic [3:0]        in_ovf_q, in_ovf_d;

  // Outbound control: a pop frees the slot the push needs, so full+pop accepts.
  assign full      = (count_q == CNT_W'(OFIFO_DEPTH));
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign stall     = reset_n && full && !pop;
  assign push      = we_port && !stall;
  assign {out_port, out_data} = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never cleared; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (reset_n && push) mem_q[wr_ptr_q] <= {port_sel, wdata};
  end

  // Inbound: a same-cycle strobe beats a read, and a read of that port excuses the overrun.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_in
      logic wr_hit, rd_hit;
      assign wr_hit         = in_strobe && (in_port == 2'(gi));
      assign rd_hit         = rd_port && (port_sel == 2'(gi));
      assign in_reg_d[gi]   = wr_hit ? in_data : in_reg_q[gi];
      assign in_fresh_d[gi] = wr_hit | (in_fresh_q[gi] & ~rd_hit);
      assign in_ovf_d[gi]   = in_ovf_q[gi] | (wr_hit & in_fresh_q[gi] & ~rd_hit);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) in_reg_q[i] <= '0;
      in_fresh_q <= '0;
      in_ovf_q   <= '0;
    end else begin
      for (int i = 0; i < 4; i++) in_reg_q[i] <= in_reg_d[i];
      in_fresh_q <= in_fresh_d;
      in_ovf_q   <= in_ovf_d;
    end
  end

  assign rdata    = in_reg_q[port_sel];
  assign in_fresh = in_fresh_q;
  assign in_ovf   = in_ovf_q;

endmodule
